wb_sram_bank_ctrl: RTL and testbench

WB_SRAM_BANK_CTRL -- requirements
Module: wb_sram_bank_ctrl

---
 rtl/wb_sram_bank_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_wb_sram_bank_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_bank_ctrl.sv
// Wishbone classic slave bridging a byte-addressed window onto NUM_BANKS
// dual-port SRAM macros (port 0 write, port 1 read).
// Optional macro WB_SRAM_BANK_CTRL_ERR_EN: out-of-range bank accesses end with
// an err pulse instead of a dummy ack (write dropped, read returns zero).
module wb_sram_bank_ctrl #(
    parameter int unsigned NUM_BANKS    = 4,
    parameter int unsigned ADDR_BITS    = 9,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_we_i,
    input  logic [3:0]                  wbs_sel_i,
    input  logic [31:0]                 wbs_adr_i,
    input  logic [31:0]                 wbs_dat_i,
    output logic                        wbs_ack_o,
    output logic                        wbs_err_o,
    output logic [31:0]                 wbs_dat_o,
    output logic [NUM_BANKS-1:0]        sram_csb0,
    output logic                        sram_web0,
    output logic [3:0]                  sram_wmask0,
    output logic [ADDR_BITS-1:0]        sram_addr0,
    output logic [31:0]                 sram_din0,
    output logic [NUM_BANKS-1:0]        sram_csb1,
    output logic [ADDR_BITS-1:0]        sram_addr1,
    input  logic [32*NUM_BANKS-1:0]     sram_dout1,
    output logic                        busy_o
);

`ifdef WB_SRAM_BANK_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int unsigned BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned BANK_LO   = ADDR_BITS + 2;
    localparam int unsigned TAG_LO    = BANK_LO + BANK_BITS;
    localparam logic [1:0]  LAST_WAIT = 2'(READ_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

    state_t                 state_q, state_d;
    logic [BANK_BITS-1:0]   bank_q, bank_d;
    logic                   we_q, we_d;
    logic [1:0]             wait_q, wait_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic [NUM_BANKS-1:0]   csb0_q, csb0_d;
    logic [NUM_BANKS-1:0]   csb1_q, csb1_d;
    logic                   web0_q, web0_d;
    logic [3:0]             wmask0_q, wmask0_d;
    logic [ADDR_BITS-1:0]   addr0_q, addr0_d;
    logic [31:0]            din0_q, din0_d;
    logic [ADDR_BITS-1:0]   addr1_q, addr1_d;

    // Address decode of the incoming request
    logic [ADDR_BITS-1:0]   req_word;
    logic [BANK_BITS-1:0]   req_bank;
    logic                   req_hit;
    logic                   req_oor;
    logic                   unused_adr;

    assign req_word   = wbs_adr_i[BANK_LO-1:2];
    assign req_bank   = wbs_adr_i[TAG_LO-1:BANK_LO];
    assign req_hit    = wbs_cyc_i && wbs_stb_i &&
                        (wbs_adr_i[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);
    assign req_oor    = 32'(req_bank) >= NUM_BANKS;
    assign unused_adr = ^wbs_adr_i[1:0];

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; a dropped cyc abandons the cycle without ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_hit) state_d = req_oor ? S_ACK : S_ACCESS;
            S_ACCESS: if (!wbs_cyc_i)  state_d = S_IDLE;
                      else if (we_q)   state_d = S_ACK;
                      else             state_d = S_WAIT;
            S_WAIT:   if (!wbs_cyc_i)  state_d = S_IDLE;
                      else if (wait_q == LAST_WAIT) state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values, registered from the upcoming state
    always_comb begin
        bank_d   = bank_q;
        we_d     = we_q;
        wait_d   = wait_q;
        rdata_d  = rdata_q;
        wmask0_d = wmask0_q;
        addr0_d  = addr0_q;
        din0_d   = din0_q;
        addr1_d  = addr1_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        busy_d   = (state_d != S_IDLE);
        csb0_d   = '1;
        csb1_d   = '1;
        web0_d   = 1'b1;

        if (state_q == S_IDLE && req_hit) begin
            bank_d = req_bank;
            we_d   = wbs_we_i;
        end

        if (state_q == S_IDLE && state_d == S_ACCESS) begin
            if (wbs_we_i) begin
                addr0_d  = req_word;
                din0_d   = wbs_dat_i;
                wmask0_d = wbs_sel_i;
                web0_d   = 1'b0;
                for (int unsigned b = 0; b < NUM_BANKS; b++)
                    csb0_d[b] = (req_bank != BANK_BITS'(b));
            end else begin
                addr1_d = req_word;
                for (int unsigned b = 0; b < NUM_BANKS; b++)
                    csb1_d[b] = (req_bank != BANK_BITS'(b));
            end
        end

        if (state_d == S_WAIT)
            wait_d = (state_q == S_WAIT) ? wait_q + 2'd1 : 2'd0;

        if (state_q == S_WAIT && state_d == S_ACK) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++)
                if (bank_q == BANK_BITS'(b)) rdata_d = sram_dout1[32*b +: 32];
        end

        if (state_d == S_ACK) begin
            if (state_q == S_IDLE) begin
                // Out-of-range bank: the SRAM is never touched
                if (ERR_EN) begin
                    err_d = 1'b1;
                end else begin
                    ack_d = 1'b1;
                    if (!wbs_we_i) rdata_d = 32'h0;
                end
            end else begin
                ack_d = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bank_q   <= '0;
            we_q     <= 1'b0;
            wait_q   <= 2'd0;
            rdata_q  <= 32'h0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            csb0_q   <= '1;
            csb1_q   <= '1;
            web0_q   <= 1'b1;
            wmask0_q <= 4'h0;
            addr0_q  <= '0;
            din0_q   <= 32'h0;
            addr1_q  <= '0;
        end else begin
            bank_q   <= bank_d;
            we_q     <= we_d;
            wait_q   <= wait_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            csb0_q   <= csb0_d;
            csb1_q   <= csb1_d;
            web0_q   <= web0_d;
            wmask0_q <= wmask0_d;
            addr0_q  <= addr0_d;
            din0_q   <= din0_d;
            addr1_q  <= addr1_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_err_o   = err_q;
    assign wbs_dat_o   = rdata_q;
    assign sram_csb0   = csb0_q;
    assign sram_web0   = web0_q;
    assign sram_wmask0 = wmask0_q;
    assign sram_addr0  = addr0_q;
    assign sram_din0   = din0_q;
    assign sram_csb1   = csb1_q;
    assign sram_addr1  = addr1_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_wb_sram_bank_ctrl.sv
// Directed bench: instance A (4 banks, read latency 2) against a behavioural
// SRAM model; instance B (3 banks, read latency 1) for out-of-range banks.
module tb_wb_sram_bank_ctrl;
    localparam int unsigned NB  = 4;
    localparam int unsigned RL  = 2;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        cyc_a, cyc_b, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;

    logic        ack_a, err_a, web0_a, busy_a;
    logic [31:0] dat_a, din0_a;
    logic [3:0]  csb0_a, csb1_a, wmask0_a;
    logic [8:0]  addr0_a, addr1_a;
    logic [127:0] dout1_a;

    logic        ack_b, err_b, web0_b, busy_b;
    logic [31:0] dat_b, din0_b;
    logic [2:0]  csb0_b, csb1_b;
    logic [3:0]  wmask0_b;
    logic [8:0]  addr0_b, addr1_b;
    logic [95:0] dout1_b;

    assign dout1_b = {32'hB0B0_0002, 32'hB0B0_0001, 32'hB0B0_0000};

    wb_sram_bank_ctrl #(.NUM_BANKS(NB), .ADDR_BITS(9), .BASE_ADDR(BASE), .READ_LATENCY(RL)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc_a), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack_a), .wbs_err_o(err_a), .wbs_dat_o(dat_a),
        .sram_csb0(csb0_a), .sram_web0(web0_a), .sram_wmask0(wmask0_a),
        .sram_addr0(addr0_a), .sram_din0(din0_a),
        .sram_csb1(csb1_a), .sram_addr1(addr1_a), .sram_dout1(dout1_a),
        .busy_o(busy_a));

    wb_sram_bank_ctrl #(.NUM_BANKS(3), .ADDR_BITS(9), .BASE_ADDR(BASE), .READ_LATENCY(1)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc_b), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack_b), .wbs_err_o(err_b), .wbs_dat_o(dat_b),
        .sram_csb0(csb0_b), .sram_web0(web0_b), .sram_wmask0(wmask0_b),
        .sram_addr0(addr0_b), .sram_din0(din0_b),
        .sram_csb1(csb1_b), .sram_addr1(addr1_b), .sram_dout1(dout1_b),
        .busy_o(busy_b));

    // Behavioural SRAM for instance A; dout is junk except when a read is due
    logic [31:0]  mem  [NB][512];
    logic [31:0]  rd_d [NB][RL];
    logic         rd_v [NB][RL];
    logic [127:0] dout_nxt;
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            for (int s = RL - 1; s > 0; s--) begin
                rd_v[b][s] = rd_v[b][s-1] && !rst;
                rd_d[b][s] = rd_d[b][s-1];
            end
            rd_v[b][0] = !csb1_a[b] && !rst;
            rd_d[b][0] = mem[b][addr1_a];
            if (!csb0_a[b] && !web0_a)
                for (int y = 0; y < 4; y++)
                    if (wmask0_a[y]) mem[b][addr0_a][8*y +: 8] = din0_a[8*y +: 8];
            dout_nxt[32*b +: 32] = rd_v[b][RL-1] ? rd_d[b][RL-1] : 32'hBAD0_BAD0;
        end
        dout1_a <= dout_nxt;
    end

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [NB][512];

    int          r_lat, r_ackn, r_errn, r_cs0_n, r_cs1_n;
    logic [3:0]  r_cs0, r_cs1, r_wmask;
    logic [8:0]  r_addr0, r_addr1;
    logic [31:0] r_din;
    logic        r_web0, r_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ref_wr(input int b, input int wd, input logic [31:0] d, input logic [3:0] s);
        for (int y = 0; y < 4; y++)
            if (s[y]) ref_mem[b][wd][8*y +: 8] = d[8*y +: 8];
    endtask

    // One Wishbone request; records SRAM-side activity, scores read data on ack
    task automatic xfer(input bit on_b, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int max_cyc, input int drop_cyc, input string tag);
        logic [3:0] c0, c1;
        logic       ak, er;
        @(negedge clk);
        we = w; adr = a; wdat = d; sel = s; stb = 1'b1;
        cyc_a = !on_b; cyc_b = on_b;
        r_lat = 0; r_ackn = 0; r_errn = 0; r_cs0_n = 0; r_cs1_n = 0;
        r_cs0 = 4'hF; r_cs1 = 4'hF; r_wmask = 4'h0; r_addr0 = '0; r_addr1 = '0;
        r_din = 32'h0; r_web0 = 1'b1; r_busy = 1'b0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            c0 = on_b ? {1'b1, csb0_b} : csb0_a;
            c1 = on_b ? {1'b1, csb1_b} : csb1_a;
            ak = on_b ? ack_b : ack_a;
            er = on_b ? err_b : err_a;
            r_busy = r_busy | (on_b ? busy_b : busy_a);
            if (c0 != 4'hF) begin
                r_cs0_n++; r_cs0 = c0;
                r_addr0 = on_b ? addr0_b : addr0_a;
                r_wmask = on_b ? wmask0_b : wmask0_a;
                r_din   = on_b ? din0_b : din0_a;
                r_web0  = on_b ? web0_b : web0_a;
            end
            if (c1 != 4'hF) begin
                r_cs1_n++; r_cs1 = c1;
                r_addr1 = on_b ? addr1_b : addr1_a;
            end
            if (ak) begin
                r_ackn++;
                if (r_lat == 0) r_lat = k;
                if (!w) begin
                    if (exp_q.size() > 0) chk({tag, "_rdata"}, on_b ? dat_b : dat_a, exp_q.pop_front());
                    else                  chk({tag, "_sb_depth"}, exp_q.size(), 1);
                end
            end
            if (er) begin
                r_errn++;
                if (r_lat == 0) r_lat = k;
            end
            if (k == drop_cyc || ak || er) begin
                cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0;
            end
        end
        cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ack", ack_a, 0);     chk("rst_err", err_a, 0);
        chk("rst_busy", busy_a, 0);   chk("rst_csb0", csb0_a, 4'hF);
        chk("rst_csb1", csb1_a, 4'hF); chk("rst_web0", web0_a, 1);
        chk("rst_dat", dat_a, 0);     chk("rst_addr0", addr0_a, 0);
        chk("rst_din0", din0_a, 0);   chk("rst_wmask", wmask0_a, 0);
        rst = 1'b0;

        // Full-word write to bank 0, word 1
        xfer(0, 1, BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 5, 0, "wr0");
        ref_wr(0, 1, 32'hDEAD_BEEF, 4'hF);
        chk("wr0_lat", r_lat, 2);      chk("wr0_ackn", r_ackn, 1);
        chk("wr0_errn", r_errn, 0);    chk("wr0_cs0n", r_cs0_n, 1);
        chk("wr0_cs0", r_cs0, 4'b1110); chk("wr0_addr0", r_addr0, 1);
        chk("wr0_din", r_din, 32'hDEAD_BEEF); chk("wr0_wmask", r_wmask, 4'hF);
        chk("wr0_web0", r_web0, 0);    chk("wr0_cs1n", r_cs1_n, 0);

        // Read it back
        exp_q.push_back(ref_mem[0][1]);
        xfer(0, 0, BASE + 32'h4, 32'h0, 4'hF, 7, 0, "rd0");
        chk("rd0_lat", r_lat, 2 + RL); chk("rd0_ackn", r_ackn, 1);
        chk("rd0_cs1n", r_cs1_n, 1);   chk("rd0_cs1", r_cs1, 4'b1110);
        chk("rd0_addr1", r_addr1, 1);  chk("rd0_cs0n", r_cs0_n, 0);

        // Bank 3, last word: full write then byte-masked write
        xfer(0, 1, 32'h3000_1FFC, 32'h1122_3344, 4'hF, 5, 0, "wr3a");
        ref_wr(3, 511, 32'h1122_3344, 4'hF);
        chk("wr3a_lat", r_lat, 2);
        xfer(0, 1, 32'h3000_1FFC, 32'hAABB_CCDD, 4'b0101, 5, 0, "wr3b");
        ref_wr(3, 511, 32'hAABB_CCDD, 4'b0101);
        chk("wr3b_wmask", r_wmask, 4'b0101); chk("wr3b_cs0", r_cs0, 4'b0111);
        chk("wr3b_cs0n", r_cs0_n, 1);        chk("wr3b_addr0", r_addr0, 9'h1FF);
        exp_q.push_back(ref_mem[3][511]);
        xfer(0, 0, 32'h3000_1FFC, 32'h0, 4'hF, 7, 0, "rd3");
        chk("rd3_lat", r_lat, 2 + RL); chk("rd3_cs1", r_cs1, 4'b0111);

        // Bank 1 write; read data register must hold across writes
        xfer(0, 1, 32'h3000_0800, 32'hCAFE_F00D, 4'hF, 5, 0, "wr1");
        ref_wr(1, 0, 32'hCAFE_F00D, 4'hF);
        chk("wr1_cs0", r_cs0, 4'b1101);
        chk("hold_dat", dat_a, 32'h11BB_33DD);

        // Outside the window: ignored entirely
        xfer(0, 0, 32'h4000_0004, 32'h0, 4'hF, 5, 0, "miss");
        chk("miss_resp", r_ackn + r_errn, 0); chk("miss_busy", r_busy, 0);
        chk("miss_cs", r_cs0_n + r_cs1_n, 0);

        // Drop cyc in the first WAIT cycle, then a fresh read
        xfer(0, 0, BASE + 32'h4, 32'h0, 4'hF, 6, 2, "abort");
        chk("abort_ackn", r_ackn, 0); chk("abort_cs1n", r_cs1_n, 1);
        exp_q.push_back(ref_mem[1][0]);
        xfer(0, 0, 32'h3000_0800, 32'h0, 4'hF, 7, 0, "rd1");
        chk("rd1_lat", r_lat, 2 + RL); chk("rd1_cs1", r_cs1, 4'b1101);

        // Three-bank instance: in-range read, then bank 3 accesses
        exp_q.push_back(32'hB0B0_0002);
        xfer(1, 0, 32'h3000_1000, 32'h0, 4'hF, 5, 0, "b_rd2");
        chk("b_rd2_lat", r_lat, 3); chk("b_rd2_cs1", r_cs1, 4'b1011);
`ifdef WB_SRAM_BANK_CTRL_ERR_EN
        xfer(1, 0, 32'h3000_1814, 32'h0, 4'hF, 5, 0, "oor_rd");
        chk("oor_rd_errn", r_errn, 1); chk("oor_rd_ackn", r_ackn, 0);
        chk("oor_rd_lat", r_lat, 1);   chk("oor_rd_cs", r_cs0_n + r_cs1_n, 0);
        chk("oor_rd_hold", dat_b, 32'hB0B0_0002);
        xfer(1, 1, 32'h3000_1814, 32'h5555_AAAA, 4'hF, 5, 0, "oor_wr");
        chk("oor_wr_errn", r_errn, 1); chk("oor_wr_ackn", r_ackn, 0);
        chk("oor_wr_cs", r_cs0_n + r_cs1_n, 0);
`else
        exp_q.push_back(32'h0);
        xfer(1, 0, 32'h3000_1814, 32'h0, 4'hF, 5, 0, "oor_rd");
        chk("oor_rd_ackn", r_ackn, 1); chk("oor_rd_errn", r_errn, 0);
        chk("oor_rd_lat", r_lat, 1);   chk("oor_rd_cs", r_cs0_n + r_cs1_n, 0);
        xfer(1, 1, 32'h3000_1814, 32'h5555_AAAA, 4'hF, 5, 0, "oor_wr");
        chk("oor_wr_ackn", r_ackn, 1); chk("oor_wr_errn", r_errn, 0);
        chk("oor_wr_cs", r_cs0_n + r_cs1_n, 0);
`endif

        // Reset asserted in the middle of an ACCESS cycle
        @(negedge clk);
        we = 1'b1; adr = BASE + 32'h8; wdat = 32'h1234_5678; sel = 4'hF; stb = 1'b1; cyc_a = 1'b1;
        @(negedge clk);
        chk("ra_cs0_pre", csb0_a, 4'b1110); chk("ra_busy_pre", busy_a, 1);
        #1 rst = 1'b1;
        #1;
        chk("ra_csb0", csb0_a, 4'hF); chk("ra_csb1", csb1_a, 4'hF);
        chk("ra_ack", ack_a, 0);      chk("ra_busy", busy_a, 0);
        chk("ra_web0", web0_a, 1);    chk("ra_dat", dat_a, 0);
        cyc_a = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ra_idle_busy", busy_a, 0); chk("ra_idle_ack", ack_a, 0);

        // Normal traffic after reset release
        xfer(0, 1, 32'h3000_101C, 32'h0BAD_F00D, 4'hF, 5, 0, "wr2");
        ref_wr(2, 7, 32'h0BAD_F00D, 4'hF);
        chk("wr2_lat", r_lat, 2); chk("wr2_cs0", r_cs0, 4'b1011);
        exp_q.push_back(ref_mem[2][7]);
        xfer(0, 0, 32'h3000_101C, 32'h0, 4'hF, 7, 0, "rd2");
        chk("rd2_lat", r_lat, 2 + RL);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
